// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, funct codes, control-field bit positions
// and the aluOp/funct decoder used by the execute stage.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOR = 3'd4,
    ALU_SLT = 3'd5
  } aluOp_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // writeBackControl = {regWrite, memToReg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  // memAccessControl = {branch, memRead, memWrite}
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  // calculationControl = {regDst, aluOp[1:0], aluSrc}
  localparam int CALC_REG_DST   = 3;
  localparam int CALC_ALU_OP_HI = 2;
  localparam int CALC_ALU_OP_LO = 1;
  localparam int CALC_ALU_SRC   = 0;

  function automatic aluOp_e decodeAluOp(input logic [1:0] aluOp, input logic [5:0] funct);
    aluOp_e sel;
    case (aluOp)
      ALUOP_ADD: sel = ALU_ADD;
      ALUOP_SUB: sel = ALU_SUB;
      ALUOP_OR:  sel = ALU_OR;
      default: begin
        case (funct)
          FUNCT_SUB: sel = ALU_SUB;
          FUNCT_AND: sel = ALU_AND;
          FUNCT_OR:  sel = ALU_OR;
          FUNCT_NOR: sel = ALU_NOR;
          FUNCT_SLT: sel = ALU_SLT;
          // FUNCT_ADD and any unrecognised funct fall back to add
          default:   sel = ALU_ADD;
        endcase
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage.
// master drives the stage inputs; slave is the execute stage itself.
interface execute_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic [1:0]            writeBackControlIn;
  logic [2:0]            memAccessControlIn;
  logic [3:0]            calculationControl;
  logic [DATA_WIDTH-1:0] programCounterIn;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic [DATA_WIDTH-1:0] immediateOperand;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;

  logic                  exMemRegWrite;
  logic [REG_ADDR_W-1:0] exMemRd;
  logic [DATA_WIDTH-1:0] exMemResult;
  logic                  memWbRegWrite;
  logic [REG_ADDR_W-1:0] memWbRd;
  logic [DATA_WIDTH-1:0] memWbResult;

  logic [1:0]            writeBackControlOut;
  logic [2:0]            memAccessControlOut;
  logic [DATA_WIDTH-1:0] branchTarget;
  logic                  zero;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [DATA_WIDTH-1:0] writeDataOut;
  logic [REG_ADDR_W-1:0] writeRegister;

  modport master (
    output writeBackControlIn, memAccessControlIn, calculationControl,
    output programCounterIn, readData1, readData2, immediateOperand,
    output rs, rt, rd,
    output exMemRegWrite, exMemRd, exMemResult,
    output memWbRegWrite, memWbRd, memWbResult,
    input  writeBackControlOut, memAccessControlOut, branchTarget, zero,
    input  aluResult, writeDataOut, writeRegister
  );

  modport slave (
    input  writeBackControlIn, memAccessControlIn, calculationControl,
    input  programCounterIn, readData1, readData2, immediateOperand,
    input  rs, rt, rd,
    input  exMemRegWrite, exMemRd, exMemResult,
    input  memWbRegWrite, memWbRd, memWbResult,
    output writeBackControlOut, memAccessControlOut, branchTarget, zero,
    output aluResult, writeDataOut, writeRegister
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage: wrapping add/sub, logic ops and
// signed set-less-than; zero flags an all-zero result.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  aluOp_e                opcode,
  input  logic [DATA_WIDTH-1:0] operandA,
  input  logic [DATA_WIDTH-1:0] operandB,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  logic signed [DATA_WIDTH-1:0] signedA;
  logic signed [DATA_WIDTH-1:0] signedB;

  assign signedA = operandA;
  assign signedB = operandB;

  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD: result = operandA + operandB;
      ALU_SUB: result = operandA - operandB;
      ALU_AND: result = operandA & operandB;
      ALU_OR:  result = operandA | operandB;
      ALU_NOR: result = ~(operandA | operandB);
      ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, (signedA < signedB)};
      default: result = operandA + operandB;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: operand select, ALU, branch target, EX/MEM register.
// Define FORWARDING_EN to resolve rs/rt from the EX/MEM and MEM/WB results.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  execute_stage_if.slave exIf
);

  logic                  regDst_p0;
  logic                  aluSrc_p0;
  logic [1:0]            aluOpField_p0;
  logic [5:0]            funct_p0;
  aluOp_e                aluSel_p0;
  logic [DATA_WIDTH-1:0] operandA_p0;
  logic [DATA_WIDTH-1:0] forwardedRt_p0;
  logic [DATA_WIDTH-1:0] operandB_p0;
  logic [DATA_WIDTH-1:0] aluOut_p0;
  logic                  aluZero_p0;
  logic [DATA_WIDTH-1:0] branchTarget_p0;
  logic [REG_ADDR_W-1:0] writeRegister_p0;

  // ---- Stage p0: decode control and resolve operands ----
  assign regDst_p0     = exIf.calculationControl[CALC_REG_DST];
  assign aluSrc_p0     = exIf.calculationControl[CALC_ALU_SRC];
  assign aluOpField_p0 = exIf.calculationControl[CALC_ALU_OP_HI:CALC_ALU_OP_LO];
  assign funct_p0      = exIf.immediateOperand[5:0];
  assign aluSel_p0     = decodeAluOp(aluOpField_p0, funct_p0);

`ifdef FORWARDING_EN
  // The younger EX/MEM result takes priority; register 0 is never forwarded.
  function automatic logic [DATA_WIDTH-1:0] forwardOperand(
    input logic [REG_ADDR_W-1:0] src,
    input logic [DATA_WIDTH-1:0] regValue,
    input logic                  exMemWr,
    input logic [REG_ADDR_W-1:0] exMemDst,
    input logic [DATA_WIDTH-1:0] exMemValue,
    input logic                  memWbWr,
    input logic [REG_ADDR_W-1:0] memWbDst,
    input logic [DATA_WIDTH-1:0] memWbValue
  );
    if (exMemWr && (exMemDst != '0) && (exMemDst == src)) return exMemValue;
    if (memWbWr && (memWbDst != '0) && (memWbDst == src)) return memWbValue;
    return regValue;
  endfunction

  assign operandA_p0 = forwardOperand(exIf.rs, exIf.readData1,
                                      exIf.exMemRegWrite, exIf.exMemRd, exIf.exMemResult,
                                      exIf.memWbRegWrite, exIf.memWbRd, exIf.memWbResult);
  assign forwardedRt_p0 = forwardOperand(exIf.rt, exIf.readData2,
                                         exIf.exMemRegWrite, exIf.exMemRd, exIf.exMemResult,
                                         exIf.memWbRegWrite, exIf.memWbRd, exIf.memWbResult);
`else
  logic unusedForwarding;

  assign operandA_p0    = exIf.readData1;
  assign forwardedRt_p0 = exIf.readData2;
  assign unusedForwarding = ^{exIf.rs, exIf.exMemRegWrite, exIf.exMemRd, exIf.exMemResult,
                              exIf.memWbRegWrite, exIf.memWbRd, exIf.memWbResult};
`endif

  assign operandB_p0      = aluSrc_p0 ? exIf.immediateOperand : forwardedRt_p0;
  assign writeRegister_p0 = regDst_p0 ? exIf.rd : exIf.rt;
  assign branchTarget_p0  = exIf.programCounterIn + (exIf.immediateOperand << 2);

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .opcode   (aluSel_p0),
    .operandA (operandA_p0),
    .operandB (operandB_p0),
    .result   (aluOut_p0),
    .zero     (aluZero_p0)
  );

  // ---- Stage p1: EX/MEM register; reset inserts a bubble, stall freezes it ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exIf.writeBackControlOut <= '0;
      exIf.memAccessControlOut <= '0;
      exIf.branchTarget        <= '0;
      exIf.zero                <= 1'b0;
      exIf.aluResult           <= '0;
      exIf.writeDataOut        <= '0;
      exIf.writeRegister       <= '0;
    end else if (!stall) begin
      exIf.writeBackControlOut <= exIf.writeBackControlIn;
      exIf.memAccessControlOut <= exIf.memAccessControlIn;
      exIf.branchTarget        <= branchTarget_p0;
      exIf.zero                <= aluZero_p0;
      exIf.aluResult           <= aluOut_p0;
      exIf.writeDataOut        <= forwardedRt_p0;
      exIf.writeRegister       <= writeRegister_p0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors queue expected EX/MEM
// contents; a monitor pops and compares them. Honors FORWARDING_EN.
module tb_execute_stage;
  import cpu_pkg::*;

  localparam int DW = 32;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;

  execute_stage_if #(.DATA_WIDTH(DW)) exIf ();

  execute_stage #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .exIf  (exIf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int testsRun = 0;
  int failures = 0;

  typedef struct packed {
    logic [95:0] name;
    logic [31:0] due;
    logic        late;
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  wr;
    logic [31:0] bt;
    logic [31:0] wd;
    logic [1:0]  wb;
    logic [2:0]  mem;
  } exp_t;

  exp_t expQ[$];

  task automatic pushExp(input logic [95:0] nm, input int dueOff, input logic late,
                         input logic [31:0] alu, input logic zero, input logic [4:0] wr,
                         input logic [31:0] bt, input logic [31:0] wd,
                         input logic [1:0] wb, input logic [2:0] mem);
    exp_t e;
    e.name = nm;
    e.due  = 32'(cyc + dueOff);
    e.late = late;
    e.alu  = alu;
    e.zero = zero;
    e.wr   = wr;
    e.bt   = bt;
    e.wd   = wd;
    e.wb   = wb;
    e.mem  = mem;
    expQ.push_back(e);
  endtask

  task automatic checkField(input logic [95:0] nm, input string field,
                            input logic [31:0] act, input logic [31:0] want);
    testsRun++;
    if (act !== want) begin
      failures++;
      $display("FAIL %0s.%0s: got 0x%08h, expected 0x%08h", nm, field, act, want);
    end
  endtask

  task automatic serve(input logic late);
    exp_t e;
    while (expQ.size() > 0 &&
           (expQ[0].due < 32'(cyc) || (expQ[0].due == 32'(cyc) && expQ[0].late <= late))) begin
      e = expQ.pop_front();
      if (e.due != 32'(cyc) || e.late != late) begin
        testsRun++;
        failures++;
        $display("FAIL %0s.schedule: checked at cycle %0d, expected cycle %0d", e.name, cyc, e.due);
      end else begin
        checkField(e.name, "aluResult",     exIf.aluResult,                   e.alu);
        checkField(e.name, "zero",          {31'd0, exIf.zero},               {31'd0, e.zero});
        checkField(e.name, "writeRegister", {27'd0, exIf.writeRegister},      {27'd0, e.wr});
        checkField(e.name, "branchTarget",  exIf.branchTarget,                e.bt);
        checkField(e.name, "writeDataOut",  exIf.writeDataOut,                e.wd);
        checkField(e.name, "wbCtrl",        {30'd0, exIf.writeBackControlOut}, {30'd0, e.wb});
        checkField(e.name, "memCtrl",       {29'd0, exIf.memAccessControlOut}, {29'd0, e.mem});
      end
    end
  endtask

  // Monitor: registered outputs at negedge+1, plus a late look just before the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      #1 serve(1'b0);
      #3 serve(1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] calc,
                       input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [4:0] rsV, input logic [4:0] rtV,
                       input logic [4:0] rdV);
    exIf.writeBackControlIn = wb;
    exIf.memAccessControlIn = mem;
    exIf.calculationControl = calc;
    exIf.programCounterIn   = pc;
    exIf.readData1          = r1;
    exIf.readData2          = r2;
    exIf.immediateOperand   = imm;
    exIf.rs                 = rsV;
    exIf.rt                 = rtV;
    exIf.rd                 = rdV;
  endtask

  task automatic setFwd(input logic exW, input logic [4:0] exRd, input logic [31:0] exRes,
                        input logic wbW, input logic [4:0] wbRd, input logic [31:0] wbRes);
    exIf.exMemRegWrite = exW;
    exIf.exMemRd       = exRd;
    exIf.exMemResult   = exRes;
    exIf.memWbRegWrite = wbW;
    exIf.memWbRd       = wbRd;
    exIf.memWbResult   = wbRes;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(2'b11, 3'b111, 4'b1111, 32'h1234, 32'h55, 32'h66, 32'h20, 5'd1, 5'd2, 5'd3);
    setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // reset held from time 0: all outputs cleared
    step();
    pushExp("reset", 0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 3'b000);

    step();
    reset = 1'b0;
    drive(2'b10, 3'b000, 4'b1100, 32'h104, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd9);
    pushExp("add", 1, 1'b0, 32'd12, 1'b0, 5'd9, 32'h184, 32'd7, 2'b10, 3'b000);

    step();
    drive(2'b00, 3'b100, 4'b0010, 32'h100, 32'h10, 32'h10, 32'hFFFF_FFFE, 5'd4, 5'd5, 5'd0);
    pushExp("beq", 1, 1'b0, 32'd0, 1'b1, 5'd5, 32'hF8, 32'h10, 2'b00, 3'b100);

    step();
    drive(2'b10, 3'b000, 4'b0111, 32'h200, 32'hF0, 32'h55, 32'h0F, 5'd1, 5'd6, 5'd0);
    pushExp("ori", 1, 1'b0, 32'hFF, 1'b0, 5'd6, 32'h23C, 32'h55, 2'b10, 3'b000);

    step();
    drive(2'b11, 3'b010, 4'b1100, 32'h0, 32'd3, 32'd5, 32'h22, 5'd1, 5'd2, 5'd7);
    pushExp("sub", 1, 1'b0, 32'hFFFF_FFFE, 1'b0, 5'd7, 32'h88, 32'd5, 2'b11, 3'b010);

    step();
    drive(2'b01, 3'b001, 4'b1100, 32'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h24, 5'd1, 5'd2, 5'd8);
    pushExp("and", 1, 1'b0, 32'h0F00_0F00, 1'b0, 5'd8, 32'h90, 32'h0FF0_0FF0, 2'b01, 3'b001);

    step();
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0000_00F0, 32'h0000_0F00, 32'h25, 5'd1, 5'd2, 5'd14);
    pushExp("orFunct", 1, 1'b0, 32'h0FF0, 1'b0, 5'd14, 32'h94, 32'h0F00, 2'b10, 3'b000);

    step();
    drive(2'b10, 3'b110, 4'b1100, 32'h0, 32'h0000_FFFF, 32'h00FF_0000, 32'h27, 5'd1, 5'd2, 5'd10);
    pushExp("nor", 1, 1'b0, 32'hFF00_0000, 1'b0, 5'd10, 32'h9C, 32'h00FF_0000, 2'b10, 3'b110);

    step();
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd1, 5'd2, 5'd11);
    pushExp("sltNeg", 1, 1'b0, 32'd1, 1'b0, 5'd11, 32'hA8, 32'd1, 2'b10, 3'b000);

    step();
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd1, 5'd2, 5'd11);
    pushExp("sltPos", 1, 1'b0, 32'd0, 1'b1, 5'd11, 32'hA8, 32'hFFFF_FFFF, 2'b10, 3'b000);

    step();
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h21, 5'd1, 5'd2, 5'd12);
    pushExp("dfltWrap", 1, 1'b0, 32'd0, 1'b1, 5'd12, 32'h84, 32'd1, 2'b10, 3'b000);

    step();
    drive(2'b10, 3'b000, 4'b0001, 32'h10, 32'h7FFF_FFFF, 32'h33, 32'd1, 5'd1, 5'd12, 5'd0);
    pushExp("addi", 1, 1'b0, 32'h8000_0000, 1'b0, 5'd12, 32'h14, 32'h33, 2'b10, 3'b000);

    // three stalled edges with changing inputs keep the addi result
    step();
    stall = 1'b1;
    drive(2'b10, 3'b000, 4'b1100, 32'h40, 32'd100, 32'd23, 32'h20, 5'd1, 5'd2, 5'd13);
    pushExp("stallHold", 1, 1'b0, 32'h8000_0000, 1'b0, 5'd12, 32'h14, 32'h33, 2'b10, 3'b000);
    step();
    drive(2'b01, 3'b111, 4'b0110, 32'h80, 32'd200, 32'd9, 32'h27, 5'd3, 5'd4, 5'd20);
    pushExp("stallHold", 1, 1'b0, 32'h8000_0000, 1'b0, 5'd12, 32'h14, 32'h33, 2'b10, 3'b000);
    step();
    drive(2'b10, 3'b000, 4'b1100, 32'h40, 32'd100, 32'd23, 32'h20, 5'd1, 5'd2, 5'd13);
    pushExp("stallHold", 1, 1'b0, 32'h8000_0000, 1'b0, 5'd12, 32'h14, 32'h33, 2'b10, 3'b000);
    step();
    stall = 1'b0;
    pushExp("stallRelease", 1, 1'b0, 32'd123, 1'b0, 5'd13, 32'hC0, 32'd23, 2'b10, 3'b000);

    // forwarding: EX/MEM wins over MEM/WB, then MEM/WB alone, then none
    step();
    setFwd(1'b1, 5'd3, 32'd40, 1'b1, 5'd3, 32'd99);
    drive(2'b10, 3'b000, 4'b0000, 32'h0, 32'd1000, 32'd2, 32'h0, 5'd3, 5'd2, 5'd0);
    pushExp("fwdExMem", 1, 1'b0, FWD ? 32'd42 : 32'd1002, 1'b0, 5'd2, 32'h0, 32'd2, 2'b10, 3'b000);

    step();
    setFwd(1'b1, 5'd0, 32'd40, 1'b1, 5'd3, 32'd99);
    pushExp("fwdMemWb", 1, 1'b0, FWD ? 32'd101 : 32'd1002, 1'b0, 5'd2, 32'h0, 32'd2, 2'b10, 3'b000);

    step();
    setFwd(1'b1, 5'd0, 32'd40, 1'b1, 5'd0, 32'd99);
    pushExp("fwdNone", 1, 1'b0, 32'd1002, 1'b0, 5'd2, 32'h0, 32'd2, 2'b10, 3'b000);

    step();
    setFwd(1'b1, 5'd3, 32'd40, 1'b0, 5'd0, 32'd0);
    drive(2'b10, 3'b001, 4'b0000, 32'h0, 32'd1, 32'd2, 32'h0, 5'd5, 5'd3, 5'd0);
    pushExp("fwdRt", 1, 1'b0, FWD ? 32'd41 : 32'd3, 1'b0, 5'd3, 32'h0,
            FWD ? 32'd40 : 32'd2, 2'b10, 3'b001);

    step();
    setFwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive(2'b11, 3'b101, 4'b1100, 32'h8, 32'd9, 32'd9, 32'h20, 5'd1, 5'd2, 5'd15);
    pushExp("preReset", 1, 1'b0, 32'd18, 1'b0, 5'd15, 32'h88, 32'd9, 2'b11, 3'b101);

    // asynchronous reset between edges, with stall also high
    step();
    #5;
    reset = 1'b1;
    stall = 1'b1;
    pushExp("asyncReset", 0, 1'b1, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 3'b000);

    step();
    pushExp("resetHeld", 0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 3'b000);
    reset = 1'b0;
    stall = 1'b0;
    pushExp("postReset", 1, 1'b0, 32'd18, 1'b0, 5'd15, 32'h88, 32'd9, 2'b11, 3'b101);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) step();
    if (expQ.size() > 0) begin
      testsRun++;
      failures++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
